// File: rtl/bus_arbiter_4req_19bit.sv
// ============================================================================
//  Module   : bus_arbiter_4req_19bit
//  Brief    : 4-requester round-robin bus arbiter with hold timeout, 19-bit mux
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter_4req_19bit #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [18:0] i1,
  input  logic [18:0] i2,
  input  logic [18:0] i3,
  input  logic [18:0] i4,
  output logic [3:0]  grant,
  output logic [1:0]  sel,
  output logic        busy,
  output logic [18:0] Q
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_ptr, w_ptr_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  w_grant_nxt;
  logic [1:0]  w_sel_nxt;
  logic        w_busy_nxt;
  logic [18:0] w_mux;
  logic [3:0]  w_others;
  logic        w_owner_req;
  logic [2:0]  w_win;

  // Returns {found, index} of the first set bit searching upward from p.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  // Owner's bit is masked so one search serves idle, release and timeout.
  assign w_others    = req & ~grant;
  assign w_owner_req = |(req & grant);
  assign w_win       = pick(w_others, r_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = grant;
    w_sel_nxt   = sel;
    w_busy_nxt  = busy;
    case (r_state)
      IDLE, BUSY: begin
        if (r_state == IDLE || !w_owner_req || r_cnt == C_HOLD_LAST) begin
          if (w_win[2]) begin
            w_state_nxt = BUSY;
            w_grant_nxt = 4'b0001 << w_win[1:0];
            w_sel_nxt   = w_win[1:0];
            w_busy_nxt  = 1'b1;
            w_ptr_nxt   = w_win[1:0] + 2'd1;
            w_cnt_nxt   = 8'd0;
          end else if (r_state == BUSY && w_owner_req) begin
            w_cnt_nxt = 8'd0;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = 4'b0000;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = 8'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_mux = '0;
    case (sel)
      2'd0:    w_mux = i1;
      2'd1:    w_mux = i2;
      2'd2:    w_mux = i3;
      default: w_mux = i4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= 8'd0;
      grant   <= 4'b0000;
      sel     <= 2'd0;
      busy    <= 1'b0;
      Q       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      grant   <= w_grant_nxt;
      sel     <= w_sel_nxt;
      busy    <= w_busy_nxt;
      Q       <= busy ? w_mux : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_4req_19bit.sv
// ============================================================================
//  Module   : tb_bus_arbiter_4req_19bit
//  Brief    : scoreboard bench for bus_arbiter_4req_19bit with reference model
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_4req_19bit;

  localparam int HOLD_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [18:0] i1 = '0, i2 = '0, i3 = '0, i4 = '0;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        busy;
  logic [18:0] Q;

  bus_arbiter_4req_19bit #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req(req),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4),
    .grant(grant), .sel(sel), .busy(busy), .Q(Q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  g;
    logic [1:0]  s;
    logic        b;
    logic [18:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: owner is -1 when the bus is free.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_cnt   = 0;
  int   m_sel   = 0;
  bit   m_busy  = 1'b0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_step();
    logic [18:0] d [4];
    logic [18:0] qn;
    logic [3:0]  others;
    int          w;
    exp_t        e;
    d  = '{i1, i2, i3, i4};
    qn = m_busy ? d[m_sel] : 19'd0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; qn = 19'd0;
    end else begin
      others = req;
      if (m_owner >= 0) others[m_owner] = 1'b0;
      if (m_owner < 0 || !req[m_owner] || m_cnt == HOLD_MAX - 1) begin
        w = first_from(others, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_cnt = 0;
        end else if (m_owner >= 0 && req[m_owner]) begin
          m_cnt = 0;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_cnt++;
      end
    end
    m_busy = (m_owner >= 0);
    e.g = m_busy ? 4'(1 << m_owner) : 4'b0000;
    e.s = 2'(m_sel);
    e.b = m_busy;
    e.q = qn;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input logic [3:0] rq, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = r;
      req = rq;
      i1 = 19'($urandom); i2 = 19'($urandom);
      i3 = 19'($urandom); i4 = 19'($urandom);
      model_step();
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (grant !== e.g) begin n_err++; $display("FAIL grant: got %b expected %b at %0t", grant, e.g, $time); end
        n_checks++;
        if (sel !== e.s) begin n_err++; $display("FAIL sel: got %0d expected %0d at %0t", sel, e.s, $time); end
        n_checks++;
        if (busy !== e.b) begin n_err++; $display("FAIL busy: got %b expected %b at %0t", busy, e.b, $time); end
        n_checks++;
        if (Q !== e.q) begin n_err++; $display("FAIL Q: got %h expected %h at %0t", Q, e.q, $time); end
      end
    end
  end

  initial begin
    logic [3:0] rq;
    bit         r;
    cyc(1'b1, 4'b0000, 2);
    // single request, then continuous contention with timeouts
    cyc(1'b0, 4'b0001, 3);
    cyc(1'b0, 4'b0000, 2);
    cyc(1'b1, 4'b0000, 1);
    cyc(1'b0, 4'b1111, 40);
    cyc(1'b0, 4'b0000, 2);
    // lone holder past the timeout, then release
    cyc(1'b0, 4'b0100, 20);
    cyc(1'b0, 4'b0000, 2);
    // hand-over with no idle cycle
    cyc(1'b0, 4'b0001, 3);
    cyc(1'b0, 4'b0100, 3);
    cyc(1'b0, 4'b0000, 2);
    // pointer wrap after requester 3
    cyc(1'b0, 4'b1000, 2);
    cyc(1'b0, 4'b0000, 2);
    cyc(1'b0, 4'b1001, 3);
    cyc(1'b0, 4'b0000, 2);
    // reset in the middle of a grant
    cyc(1'b0, 4'b0010, 3);
    cyc(1'b1, 4'b0010, 1);
    cyc(1'b0, 4'b0011, 3);
    cyc(1'b0, 4'b0000, 2);
    // random traffic: slowly changing requests, rare resets
    rq = 4'b0000;
    for (int k = 0; k < 800; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      r = ($urandom_range(0, 127) == 0);
      cyc(r, rq, 1);
    end
    cyc(1'b0, 4'b0000, 3);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter_4req_19bit.md
BUS_ARBITER_4REQ_19BIT -- requirements
Module: bus_arbiter_4req_19bit

Interface
REQ-001 The block SHALL have one parameter: HOLD_MAX, default 8, legal range 2..255; the maximum consecutive grant cycles under contention.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  4  request lines; bit k is requester k, held high while the requester wants or uses the bus.
REQ-005 i1, i2, i3, i4  input  19 each  requester data; i1 belongs to requester 0, i4 to requester 3.
REQ-006 grant  output  4  one-hot registered grant; all zero when idle.
REQ-007 sel  output  2  registered index of the current owner; drives the select of the 4-to-1 19-bit mux.
REQ-008 busy  output  1  registered; high while any grant is asserted.
REQ-009 Q  output  19  registered bus data.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one owner).
REQ-011 Internal state SHALL comprise a 2-bit round-robin pointer ptr and an 8-bit hold counter cnt.
REQ-012 Arbitration SHALL search req starting at index ptr, ascending, wrapping 3->0; the first set bit wins.
REQ-013 On each new grant to requester k, the block SHALL set ptr to (k+1) mod 4 and cnt to 0.
REQ-014 IDLE -> BUSY: if req != 0 in cycle N, grant, sel and busy SHALL reflect the winner from cycle N+1.
REQ-015 In BUSY, cnt SHALL increment by 1 each cycle the owner keeps its grant.
REQ-016 Release: if req[owner] is 0 in cycle N, the owner's grant SHALL drop at N+1.
REQ-017 On release with other requests pending in cycle N, the next winner SHALL be granted at N+1, with no idle cycle.
REQ-018 On release with no other requests pending, the FSM SHALL go to IDLE at N+1.
REQ-019 Timeout: if cnt == HOLD_MAX-1 and req[owner] is still 1, the block SHALL re-arbitrate with the owner's bit masked.
REQ-020 On timeout with another requester pending, the grant SHALL pass to the winner at N+1.
REQ-021 On timeout with no other requester pending, the owner SHALL keep the grant, cnt SHALL reset to 0, and ptr SHALL be unchanged.
REQ-022 grant SHALL be one-hot or zero at all times, and SHALL never change in a cycle unless REQ-014/016/019 applies.
REQ-023 sel SHALL equal the index of the set grant bit; sel SHALL hold its last value while idle.
REQ-024 Q SHALL be registered with one cycle latency: Q(N+1) = input selected by sel(N) if busy(N), else 0.
REQ-025 Q therefore SHALL lag grant by one cycle, and the first owner data SHALL appear at N+2 relative to the request.
REQ-026 Requests asserted while BUSY SHALL be considered only at release or timeout.
REQ-027 The block SHALL keep no queue: a requester that drops req before being granted is forgotten.

Reset
REQ-028 While rst = 1 at a clock edge, the next state SHALL be: FSM = IDLE, grant = 0000, sel = 00, busy = 0, Q = 0, ptr = 0, cnt = 0.
REQ-029 rst SHALL take priority over every other event, including mid-grant; req SHALL be ignored in any cycle where rst = 1.
REQ-030 Arbitration after reset deassertion SHALL start from ptr = 0.

Verification
REQ-031 Scenario 1: after reset, req=0001 at cycle 0 -> cycle 1: grant=0001, sel=00, busy=1; cycle 2: Q=i1.
REQ-032 Scenario 2: from reset, req=1111 held continuously with HOLD_MAX=8 -> grant is 0001 for 8 cycles, then 0010, 0100, 1000, 0001, each exactly 8 cycles, with no gaps.
REQ-033 Scenario 3: req=0100 alone, held for 20 cycles -> grant=0100 for all 20 cycles, cnt wraps at 7 and the grant is never dropped; grant=0000 one cycle after req falls.
REQ-034 Scenario 4: owner 0 drops req in the same cycle that req[2] rises (req=0100) -> next cycle grant=0100, with busy continuously 1.
REQ-035 Scenario 5: requester 3 is granted then releases, then req=1001 -> grant=0001, because ptr has wrapped to 0.
REQ-036 Scenario 6: rst asserted for 1 cycle during a grant to requester 1 -> next cycle grant=0000, busy=0, Q=0; subsequent req=0011 -> grant=0001.
